// File: rtl/tt_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_pwm_pkg
// Description : Shared constants and enums for the PWM bank. Holds the
//               register address map, the counting-mode enum and the
//               center-mode counter FSM state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_pwm_pkg;

  // Register address map (DUTY shadows occupy 0..7)
  localparam logic [3:0] ADDR_DUTY0    = 4'd0;
  localparam logic [3:0] ADDR_ENABLE   = 4'd8;
  localparam logic [3:0] ADDR_PRESCALE = 4'd9;
  localparam logic [3:0] ADDR_TOP      = 4'd10;
  localparam logic [3:0] ADDR_CTRL     = 4'd11;

  // Counting mode
  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } mode_e;

  // Center-mode counter direction
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tt_pwm_sync.sv
`default_nettype none
// ============================================================================
// Module      : tt_pwm_sync
// Description : Two-flop synchronizer for an asynchronous strobe followed by
//               a rising-edge detector. rise_o is high for exactly one clk
//               cycle per strobe assertion.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_pwm_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/tt_um_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_pwm_bank
// Description : Bank of NCH PWM channels sharing one prescaler and one
//               edge/center-aligned counter. Duty, TOP and mode are
//               double-buffered and swap in at period boundaries; enable
//               mask and polarity act immediately. Registers are written
//               through an asynchronous strobe on ui_in[7].
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_pwm_bank
  import tt_pwm_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int WIDTH = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n,
  input  logic       VGND,
  input  logic       VDPWR,
  inout  wire  [7:0] ua
);

  logic                       wr_stb;
  logic [3:0]                 addr;
  logic [WIDTH-1:0]           wdata;

  logic [NCH-1:0][WIDTH-1:0]  duty_sh_q;
  logic [NCH-1:0][WIDTH-1:0]  duty_act_q;
  logic [NCH-1:0]             enable_q;
  logic [WIDTH-1:0]           prescale_q;
  logic [WIDTH-1:0]           top_sh_q;
  logic [WIDTH-1:0]           top_act_q;
  logic [1:0]                 ctrl_q;
  mode_e                      mode_act_q;

  logic [WIDTH-1:0]           psc_q;
  logic                       tick;
  logic [WIDTH-1:0]           cnt_q;
  logic [WIDTH-1:0]           cnt_d;
  state_e                     state_q;
  state_e                     state_d;
  logic                       boundary;

  logic [NCH-1:0]             out_d;
  logic [NCH-1:0]             out_q;

  logic                       unused_ok;

  tt_pwm_sync u_sync (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .async_i (ui_in[7]),
    .rise_o  (wr_stb)
  );

  assign addr  = ui_in[3:0];
  assign wdata = uio_in[WIDTH-1:0];

  // Register file: shadows, enable mask, prescale and control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh_q  <= '0;
      enable_q   <= '0;
      prescale_q <= '0;
      top_sh_q   <= '1;
      ctrl_q     <= 2'b00;
    end else if (wr_stb) begin
      for (int i = 0; i < NCH; i++) begin
        if (addr == 4'(i)) duty_sh_q[i] <= wdata;
      end
      case (addr)
        ADDR_ENABLE:   enable_q   <= uio_in[NCH-1:0];
        ADDR_PRESCALE: prescale_q <= wdata;
        ADDR_TOP:      top_sh_q   <= wdata;
        ADDR_CTRL:     ctrl_q     <= uio_in[1:0];
        default:       ;
      endcase
    end
  end

  // A tick is the prescaler's terminal count; frozen while ena is low
  assign tick = ena && (psc_q == prescale_q);

  // Prescaler, restarted on every PRESCALE write so a new ratio starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
    end else if (wr_stb && (addr == ADDR_PRESCALE)) begin
      psc_q <= '0;
    end else if (tick) begin
      psc_q <= '0;
    end else if (ena) begin
      psc_q <= psc_q + WIDTH'(1);
    end
  end

  // Counter next state: edge wraps at TOP, center runs UP then DOWN
  always_comb begin
    cnt_d    = cnt_q;
    state_d  = state_q;
    boundary = 1'b0;
    if (tick) begin
      if (top_act_q == '0) begin
        cnt_d    = '0;
        boundary = 1'b1;
      end else if (mode_act_q == EDGE) begin
        if (cnt_q >= top_act_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        case (state_q)
          UP: begin
            if (cnt_q >= top_act_q) begin
              cnt_d   = cnt_q - WIDTH'(1);
              state_d = DOWN;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
              if (cnt_q == top_act_q - WIDTH'(1)) state_d = DOWN;
            end
          end
          DOWN: begin
            if (cnt_q <= WIDTH'(1)) begin
              cnt_d    = '0;
              boundary = 1'b1;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
      // Every period starts counting upward
      if (boundary) state_d = UP;
    end
  end

  // Counter/FSM state and boundary transfer of shadows into active copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      state_q    <= UP;
      top_act_q  <= '1;
      mode_act_q <= EDGE;
      duty_act_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      if (boundary) begin
        top_act_q  <= top_sh_q;
        mode_act_q <= mode_e'(ctrl_q[0]);
        duty_act_q <= duty_sh_q;
      end
    end
  end

  // Per-channel compare, enable gating and polarity
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign out_d[gi] = ((cnt_q < duty_act_q[gi]) & enable_q[gi]) ^ ctrl_q[1];
  end

  // Output register; holds its value while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (ena) begin
      out_q <= out_d;
    end
  end

  // Drive unused channel bits low
  always_comb begin
    uo_out          = 8'h00;
    uo_out[NCH-1:0] = out_q;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Pins with no logic function
  assign unused_ok = &{1'b0, VGND, VDPWR, ui_in, uio_in, ua};

endmodule
`default_nettype wire
